top: RTL and testbench



---
 rtl/top.sv | 73 +++++++
 tb/tb_top.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/top.sv
// Parallel bank of delay lines: ungated taps at depths 1/3/5/9 and enable-gated
// taps at depths 2/4/6/10, each its own shift register, every bit an independent lane.
module top #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] a,
  input  logic         e,
  output logic [N-1:0] z1,
  output logic [N-1:0] z2,
  output logic [N-1:0] z3,
  output logic [N-1:0] z4,
  output logic [N-1:0] z5,
  output logic [N-1:0] z6,
  output logic [N-1:0] z9,
  output logic [N-1:0] z10
);

  // Element [0] is the stage fed by a; the highest element drives the output.
  logic [N-1:0]       u1_q, u1_d;
  logic [2:0][N-1:0]  u3_q, u3_d;
  logic [4:0][N-1:0]  u5_q, u5_d;
  logic [8:0][N-1:0]  u9_q, u9_d;
  logic [1:0][N-1:0]  g2_q, g2_d;
  logic [3:0][N-1:0]  g4_q, g4_d;
  logic [5:0][N-1:0]  g6_q, g6_d;
  logic [9:0][N-1:0]  g10_q, g10_d;

  always_comb begin
    u1_d  = a;
    u3_d  = {u3_q[1:0], a};
    u5_d  = {u5_q[3:0], a};
    u9_d  = {u9_q[7:0], a};
    // Gated lines move as a whole or not at all.
    g2_d  = e ? {g2_q[0],    a} : g2_q;
    g4_d  = e ? {g4_q[2:0],  a} : g4_q;
    g6_d  = e ? {g6_q[4:0],  a} : g6_q;
    g10_d = e ? {g10_q[8:0], a} : g10_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      u1_q  <= '0;
      u3_q  <= '0;
      u5_q  <= '0;
      u9_q  <= '0;
      g2_q  <= '0;
      g4_q  <= '0;
      g6_q  <= '0;
      g10_q <= '0;
    end else begin
      u1_q  <= u1_d;
      u3_q  <= u3_d;
      u5_q  <= u5_d;
      u9_q  <= u9_d;
      g2_q  <= g2_d;
      g4_q  <= g4_d;
      g6_q  <= g6_d;
      g10_q <= g10_d;
    end
  end

  assign z1  = u1_q;
  assign z3  = u3_q[2];
  assign z5  = u5_q[4];
  assign z9  = u9_q[8];
  assign z2  = g2_q[1];
  assign z4  = g4_q[3];
  assign z6  = g6_q[5];
  assign z10 = g10_q[9];

endmodule

// File: tb/tb_top.sv
// Directed bench for the delay-line bank: pulse latencies, enable freeze,
// async reset mid-stream, and a randomized stretch against a tap-chain model.
module tb_top;
  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] a = '0;
  logic         e = 1'b0;
  logic [N-1:0] z1, z2, z3, z4, z5, z6, z9, z10;

  int tests = 0;
  int fails = 0;

  // Model: one 9-deep free-running chain and one 10-deep gated chain, tapped.
  logic [N-1:0] mu [0:8];
  logic [N-1:0] mg [0:9];

  top #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .e(e),
    .z1(z1), .z2(z2), .z3(z3), .z4(z4), .z5(z5), .z6(z6), .z9(z9), .z10(z10)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [N-1:0] e1, e2, e3, e4, e5, e6, e9, e10);
    chk({tag, "_z1"}, z1, e1);
    chk({tag, "_z2"}, z2, e2);
    chk({tag, "_z3"}, z3, e3);
    chk({tag, "_z4"}, z4, e4);
    chk({tag, "_z5"}, z5, e5);
    chk({tag, "_z6"}, z6, e6);
    chk({tag, "_z9"}, z9, e9);
    chk({tag, "_z10"}, z10, e10);
  endtask

  task automatic model_clear();
    for (int i = 0; i < 9; i++) mu[i] = '0;
    for (int i = 0; i < 10; i++) mg[i] = '0;
  endtask

  // Advance one rising edge; the model uses the inputs that were set up before it.
  task automatic tick();
    logic [N-1:0] a_s;
    logic         e_s;
    logic         r_s;
    a_s = a; e_s = e; r_s = rst_n;
    @(posedge clk);
    if (!r_s) model_clear();
    else begin
      for (int i = 8; i > 0; i--) mu[i] = mu[i-1];
      mu[0] = a_s;
      if (e_s) begin
        for (int i = 9; i > 0; i--) mg[i] = mg[i-1];
        mg[0] = a_s;
      end
    end
    #1;
  endtask

  task automatic chk_model(input string tag);
    chk_all(tag, mu[0], mg[1], mu[2], mg[3], mu[4], mg[5], mu[8], mg[9]);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_clear();
    chk_all("rst", '0, '0, '0, '0, '0, '0, '0, '0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One-cycle pulse with e held high: every tap shows v on exactly the edge equal to its depth.
  task automatic pulse_test(input string tag, input logic [N-1:0] v);
    do_reset();
    a = v; e = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      tick();
      a = '0;
      chk_all(tag,
        (k == 1) ? v : '0, (k == 2) ? v : '0, (k == 3) ? v : '0, (k == 4) ? v : '0,
        (k == 5) ? v : '0, (k == 6) ? v : '0, (k == 9) ? v : '0, (k == 10) ? v : '0);
    end
  endtask

  initial begin
    int tot;
    int en;
    logic [N-1:0] v;

    #1;
    chk_all("por", '0, '0, '0, '0, '0, '0, '0, '0);

    pulse_test("pulse_a5", 8'hA5);
    pulse_test("pulse_3c", 8'h3C);

    // Enable freeze: two enabled edges, seven disabled, then enabled again.
    do_reset();
    v = 8'h81;
    tot = 0; en = 0;
    for (int k = 1; k <= 19; k++) begin
      a = (k == 1) ? v : '0;
      e = (k >= 3 && k <= 9) ? 1'b0 : 1'b1;
      if (e) en++;
      tot++;
      tick();
      chk_all("freeze",
        (tot == 1) ? v : '0, (en == 2) ? v : '0, (tot == 3) ? v : '0, (en == 4) ? v : '0,
        (tot == 5) ? v : '0, (en == 6) ? v : '0, (tot == 9) ? v : '0, (en == 10) ? v : '0);
    end

    // Fill with FF, then reset between edges.
    a = 8'hFF; e = 1'b1;
    for (int k = 0; k < 10; k++) tick();
    chk_all("full", 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_all("async_rst", '0, '0, '0, '0, '0, '0, '0, '0);
    tick();
    chk_all("rst_hold", '0, '0, '0, '0, '0, '0, '0, '0);
    @(negedge clk);
    rst_n = 1'b1;
    a = '0;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk_all("drain", '0, '0, '0, '0, '0, '0, '0, '0);
    end
    a = 8'h5A;
    tick();
    chk_all("restart", 8'h5A, '0, '0, '0, '0, '0, '0, '0);

    // Random stretch, checked after each rising edge and on the following falling edge.
    do_reset();
    for (int k = 0; k < 3 * N * 10; k++) begin
      a = N'($urandom);
      e = 1'($urandom_range(0, 1));
      tick();
      chk_model("rnd_pos");
      @(negedge clk);
      chk_model("rnd_neg");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
